// File: rtl/rr_arb4_sel.sv
//==============================================================================
// Module   : rr_arb4_sel
// Brief    : 4-channel round-robin arbiter with a registered valid/ready output
//            stage. It drives the downstream 4:1 mux select.
//            Optional macro RR_ARB_LOCK_EN adds a 'lock' input for burst
//            re-grant to the previous winner.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module rr_arb4_sel #(
    parameter int DW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    req,
    input  logic [DW-1:0] d0,
    input  logic [DW-1:0] d1,
    input  logic [DW-1:0] d2,
    input  logic [DW-1:0] d3,
`ifdef RR_ARB_LOCK_EN
    input  logic          lock,
`endif
    input  logic          out_ready,
    output logic [3:0]    gnt,
    output logic [1:0]    sel,
    output logic          out_valid,
    output logic [DW-1:0] out_data
);

    logic [1:0]    r_ptr;
    logic [1:0]    r_sel;
    logic          r_out_valid;
    logic [DW-1:0] r_out_data;
    logic          r_has_winner;

    logic          w_can_accept;
    logic          w_found;
    logic [1:0]    w_winner;
    logic          w_accept;
    logic          w_hold_ptr;
    logic [DW-1:0] w_win_data;

    assign w_can_accept = !r_out_valid || out_ready;

    always_comb begin
        logic [1:0] idx;
        idx        = '0;
        w_found    = 1'b0;
        w_winner   = '0;
        w_hold_ptr = 1'b0;
        // Scan from the priority pointer upward, wrapping 3 -> 0.
        for (int k = 0; k < 4; k++) begin
            idx = r_ptr + k[1:0];
            if (!w_found && req[idx]) begin
                w_found  = 1'b1;
                w_winner = idx;
            end
        end
`ifdef RR_ARB_LOCK_EN
        if (lock && r_has_winner && req[r_sel]) begin
            w_found    = 1'b1;
            w_winner   = r_sel;
            w_hold_ptr = 1'b1;
        end
`endif
    end

    assign w_accept = w_can_accept && w_found && !rst;
    assign gnt      = w_accept ? (4'b0001 << w_winner) : 4'b0000;

    always_comb begin
        case (w_winner)
            2'd0:    w_win_data = d0;
            2'd1:    w_win_data = d1;
            2'd2:    w_win_data = d2;
            default: w_win_data = d3;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr        <= '0;
            r_sel        <= '0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_has_winner <= 1'b0;
        end else if (w_accept) begin
            r_out_data   <= w_win_data;
            r_sel        <= w_winner;
            r_out_valid  <= 1'b1;
            r_has_winner <= 1'b1;
            if (!w_hold_ptr) begin
                r_ptr <= w_winner + 2'd1;
            end
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign sel       = r_sel;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

endmodule

`default_nettype wire

// File: tb/tb_rr_arb4_sel.sv
//==============================================================================
// Module   : tb_rr_arb4_sel
// Brief    : Directed vector table plus hand sequences for rr_arb4_sel.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_rr_arb4_sel;

    localparam int DW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    req;
    logic [DW-1:0] d0, d1, d2, d3;
    logic          out_ready;
    logic [3:0]    gnt;
    logic [1:0]    sel;
    logic          out_valid;
    logic [DW-1:0] out_data;
`ifdef RR_ARB_LOCK_EN
    logic          lock;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rr_arb4_sel #(.DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .d0        (d0),
        .d1        (d1),
        .d2        (d2),
        .d3        (d3),
`ifdef RR_ARB_LOCK_EN
        .lock      (lock),
`endif
        .out_ready (out_ready),
        .gnt       (gnt),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

    // Inputs applied before the edge; gnt checked before it, registers after.
    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       rdy;
        logic [1:0] d0, d1, d2, d3;
        logic [3:0] gnt;
        logic       vld;
        logic [1:0] sel;
        logic [1:0] dat;
    } vec_t;

    vec_t vt[$];

    task automatic check(input string name, input int row, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s row=%0d actual=%0d expected=%0d", name, row, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic [3:0] q, input logic y,
                                input logic [1:0] a0, input logic [1:0] a1,
                                input logic [1:0] a2, input logic [1:0] a3,
                                input logic [3:0] g, input logic v,
                                input logic [1:0] s, input logic [1:0] o);
        vec_t t;
        t.rst = r; t.req = q; t.rdy = y;
        t.d0 = a0; t.d1 = a1; t.d2 = a2; t.d3 = a3;
        t.gnt = g; t.vld = v; t.sel = s; t.dat = o;
        return t;
    endfunction

    task automatic step_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req = '0; out_ready = 1'b1;
        d0 = 2'd3; d1 = 2'd0; d2 = 2'd1; d3 = 2'd2;
`ifdef RR_ARB_LOCK_EN
        lock = 1'b0;
`endif
        //          rst  req      rdy  d0 d1 d2 d3  gnt      vld sel dat
        // reset held with all requesting
        vt.push_back(mk(1, 4'b1111, 1, 3, 0, 1, 2, 4'b0000, 0, 0, 0));
        vt.push_back(mk(1, 4'b1111, 1, 3, 0, 1, 2, 4'b0000, 0, 0, 0));
        // full rotation 0,1,2,3,0
        vt.push_back(mk(0, 4'b1111, 1, 3, 0, 1, 2, 4'b0001, 1, 0, 3));
        vt.push_back(mk(0, 4'b1111, 1, 3, 0, 1, 2, 4'b0010, 1, 1, 0));
        vt.push_back(mk(0, 4'b1111, 1, 3, 0, 1, 2, 4'b0100, 1, 2, 1));
        vt.push_back(mk(0, 4'b1111, 1, 3, 0, 1, 2, 4'b1000, 1, 3, 2));
        vt.push_back(mk(0, 4'b1111, 1, 3, 0, 1, 2, 4'b0001, 1, 0, 3));
        // backpressure: 3 stalled cycles, then release
        vt.push_back(mk(0, 4'b1111, 0, 3, 0, 1, 2, 4'b0000, 1, 0, 3));
        vt.push_back(mk(0, 4'b1111, 0, 3, 0, 1, 2, 4'b0000, 1, 0, 3));
        vt.push_back(mk(0, 4'b1111, 0, 3, 0, 1, 2, 4'b0000, 1, 0, 3));
        vt.push_back(mk(0, 4'b1111, 1, 3, 0, 1, 2, 4'b0010, 1, 1, 0));
        // wrap with sparse requests (ptr=2)
        vt.push_back(mk(0, 4'b0011, 1, 3, 0, 1, 2, 4'b0001, 1, 0, 3));
        vt.push_back(mk(0, 4'b0011, 1, 3, 0, 1, 2, 4'b0010, 1, 1, 0));
        // drain, then idle: ptr must stay at 2
        vt.push_back(mk(0, 4'b0000, 1, 3, 0, 1, 2, 4'b0000, 0, 1, 0));
        vt.push_back(mk(0, 4'b0000, 1, 3, 0, 1, 2, 4'b0000, 0, 1, 0));
        vt.push_back(mk(0, 4'b1111, 0, 3, 0, 1, 2, 4'b0100, 1, 2, 1));
        vt.push_back(mk(0, 4'b1111, 1, 3, 0, 1, 2, 4'b1000, 1, 3, 2));
        // stall holding data 2, then reset mid-operation
        vt.push_back(mk(0, 4'b1111, 0, 3, 0, 1, 2, 4'b0000, 1, 3, 2));
        vt.push_back(mk(1, 4'b1111, 0, 3, 0, 1, 2, 4'b0000, 0, 0, 0));
        vt.push_back(mk(0, 4'b1100, 0, 3, 0, 1, 2, 4'b0100, 1, 2, 1));
        vt.push_back(mk(0, 4'b1100, 1, 3, 0, 1, 2, 4'b1000, 1, 3, 2));
        vt.push_back(mk(0, 4'b0100, 1, 3, 0, 3, 2, 4'b0100, 1, 2, 3));
        vt.push_back(mk(0, 4'b0000, 1, 3, 0, 3, 2, 4'b0000, 0, 2, 3));

        @(negedge clk);
        foreach (vt[i]) begin
            rst = vt[i].rst; req = vt[i].req; out_ready = vt[i].rdy;
            d0 = vt[i].d0; d1 = vt[i].d1; d2 = vt[i].d2; d3 = vt[i].d3;
            #1;
            check("gnt", i, int'(gnt), int'(vt[i].gnt));
            step_edge();
            check("out_valid", i, int'(out_valid), int'(vt[i].vld));
            check("sel", i, int'(sel), int'(vt[i].sel));
            check("out_data", i, int'(out_data), int'(vt[i].dat));
        end

        // gnt follows out_ready combinationally while a word is held
        req = 4'b0001; out_ready = 1'b1; d0 = 2'd1;
        step_edge();
        out_ready = 1'b0; #1;
        check("gnt_stall_comb", 100, int'(gnt), 0);
        out_ready = 1'b1; #1;
        check("gnt_ready_comb", 101, int'(gnt), 1);
        step_edge();
        check("out_data_b2b", 102, int'(out_data), 1);
        check("out_valid_b2b", 103, int'(out_valid), 1);

`ifdef RR_ARB_LOCK_EN
        // lock re-grants the previous winner and keeps the pointer frozen
        rst = 1'b1; req = 4'b1111; out_ready = 1'b1; lock = 1'b0;
        d0 = 2'd3; d1 = 2'd0; d2 = 2'd1; d3 = 2'd2;
        step_edge();
        rst = 1'b0; lock = 1'b1; #1;
        check("lock_first_gnt", 200, int'(gnt), 1);
        step_edge();
        for (int k = 0; k < 3; k++) begin
            #1;
            check("lock_regnt", 201 + k, int'(gnt), 1);
            step_edge();
            check("lock_sel", 201 + k, int'(sel), 0);
        end
        lock = 1'b0; #1;
        check("unlock_gnt", 210, int'(gnt), 2);
        step_edge();
        check("unlock_data", 211, int'(out_data), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
